// File: rtl/iir_out_serializer_if.sv
// Sample-in / serial-out bundle for iir_out_serializer.
// The master side is the producer of samples and the consumer of the serial stream.
interface iir_out_serializer_if #(
  parameter int NB_DATA    = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NB_DATA-1:0] i_y;
  logic               i_valid;
  logic               i_clear_ovf;
  logic               o_sdata;
  logic               o_frame;
  logic               o_busy;
  logic [CW-1:0]      o_fifo_count;
  logic               o_overflow;

  modport master (
    output i_y, i_valid, i_clear_ovf,
    input  o_sdata, o_frame, o_busy, o_fifo_count, o_overflow
  );

  modport slave (
    input  i_y, i_valid, i_clear_ovf,
    output o_sdata, o_frame, o_busy, o_fifo_count, o_overflow
  );
endinterface

// File: rtl/iir_out_serializer.sv
// Buffers IIR filter output samples in a small FIFO and sends each one
// MSB first on a single serial line, framed by o_frame, with a one-cycle
// gap state between frames. Drops samples when full and flags it.
module iir_out_serializer #(
  parameter int NB_DATA    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  i_rst_n,
  iir_out_serializer_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(NB_DATA);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [BW-1:0]      bitcnt_q, bitcnt_d;

  logic [NB_DATA-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a
  // sample while the transmitter is taking the head.
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = (state_q == ST_IDLE) && (count_q != '0);
  assign push = bus.i_valid && (!full || pop);
  assign drop = bus.i_valid && !push;

  // Transmitter next state: load head on pop, shift MSB-first, then gap.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d  = ST_SHIFT;
          shreg_d  = mem[rd_ptr_q];
          bitcnt_d = '0;
        end
      end
      ST_SHIFT: begin
        shreg_d  = {shreg_q[NB_DATA-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == BW'(NB_DATA - 1)) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping and sticky overflow; a drop beats a clear on the same edge.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.i_clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State, datapath and FIFO control registers.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, as flops do.
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage.
  // NOTE: storage has no reset; entries are only read after being written, and count gates validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.i_y;
    end
  end

  assign bus.o_frame      = (state_q == ST_SHIFT);
  assign bus.o_sdata      = (state_q == ST_SHIFT) && shreg_q[NB_DATA-1];
  assign bus.o_busy       = (state_q != ST_IDLE) || (count_q != '0);
  assign bus.o_fifo_count = count_q;
  assign bus.o_overflow   = ovf_q;

endmodule
